// File: rtl/icache_line_fill.sv
// ---------------------------------------------------------------------------
// icache_line_fill
//   Instruction-cache miss handler. It fetches one cache line from memory as
//   a burst and writes each word into the 4-way instruction data RAM. It then
//   writes the tag/valid entry and pulses miss_ack back to the fetch stage.
//   Victim ways are partitioned by security domain. Low-domain misses fill
//   ways 0-1 and high-domain misses fill ways 2-3. Each (domain, set) pair has
//   its own 1-bit round-robin pointer, so one domain never reads or disturbs
//   the other domain's replacement state.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   miss_req/addr/dom      miss request from fetch; held until miss_ack
//   miss_ack               one-cycle pulse once the line is filled and tagged
//   busy                   high whenever the handler is not idle
//   mem_req/addr/gnt       line-aligned burst read request and its grant
//   mem_rvalid/rdata       read beats, in word order
//   ram_en/we/index/way/
//   ram_offset/din         data RAM write port
//   tag_we/index/way/data  tag array write port (valid is set implicitly)
// ---------------------------------------------------------------------------
module icache_line_fill #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int INDEX_W = 5,
  parameter int WO_W    = 2,
  parameter int TAG_W   = AW - INDEX_W - WO_W - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               miss_req,
  input  logic [AW-1:0]      miss_addr,
  input  logic               miss_dom,
  output logic               miss_ack,
  output logic               busy,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [DW-1:0]      mem_rdata,
  output logic               ram_en,
  output logic               ram_we,
  output logic [INDEX_W-1:0] ram_index,
  output logic [1:0]         ram_way,
  output logic [WO_W-1:0]    ram_offset,
  output logic [DW-1:0]      ram_din,
  output logic               tag_we,
  output logic [INDEX_W-1:0] tag_index,
  output logic [1:0]         tag_way,
  output logic [TAG_W-1:0]   tag_data
);

  // The line address drops the word and byte offset bits. It holds the tag
  // in its upper bits and the set index in its lower bits.
  localparam int LINE_W = AW - WO_W - 2;
  localparam int NPTR   = 2 * (2 ** INDEX_W);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    TAG,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LINE_W-1:0]  line_q;
  logic [1:0]         way_q;
  logic [WO_W-1:0]    cnt_q;
  logic               beat_vld_q;
  logic [WO_W-1:0]    beat_off_q;
  logic [DW-1:0]      beat_data_q;
  logic [NPTR-1:0]    ptr_q;

  logic [INDEX_W-1:0] miss_index;
  logic [INDEX_W-1:0] fill_index;
  logic               beat_accept;
  logic               last_beat;
  logic               unused_addr_bits;

  // Byte and word offset bits of the miss address are irrelevant here,
  // because the whole line is always fetched.
  assign unused_addr_bits = ^miss_addr[WO_W+1:0];

  assign miss_index  = miss_addr[WO_W+2 +: INDEX_W];
  assign fill_index  = line_q[INDEX_W-1:0];
  assign beat_accept = (state_q == FILL) && mem_rvalid;
  assign last_beat   = beat_accept && (cnt_q == {WO_W{1'b1}});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (miss_req) state_d = REQ;
      REQ:  if (mem_gnt) state_d = FILL;
      FILL: if (last_beat) state_d = TAG;
      TAG:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Miss capture. The victim way is frozen here, so changes to the inputs
  // while busy have no effect. Only the requesting domain's pointer is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      way_q  <= '0;
    end else if (state_q == IDLE && miss_req) begin
      line_q <= miss_addr[AW-1:WO_W+2];
      way_q  <= {miss_dom, ptr_q[{miss_dom, miss_index}]};
    end
  end

  // Beat counter and one-stage beat register. Each beat becomes a RAM write
  // in the following cycle. The last write therefore lands in TAG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      beat_vld_q  <= 1'b0;
      beat_off_q  <= '0;
      beat_data_q <= '0;
    end else begin
      beat_vld_q <= beat_accept;
      if (beat_accept) begin
        cnt_q       <= cnt_q + 1'b1;
        beat_off_q  <= cnt_q;
        beat_data_q <= mem_rdata;
      end
    end
  end

  // Round-robin pointers. The filling domain's pointer for the set toggles
  // only when the tag is committed. An aborted fill leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == TAG) begin
      ptr_q[{way_q[1], fill_index}] <= ~ptr_q[{way_q[1], fill_index}];
    end
  end

  // Output decode. Every port idles at zero when it is not in use.
  always_comb begin
    miss_ack   = 1'b0;
    busy       = (state_q != IDLE);
    mem_req    = 1'b0;
    mem_addr   = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_index  = '0;
    ram_way    = '0;
    ram_offset = '0;
    ram_din    = '0;
    tag_we     = 1'b0;
    tag_index  = '0;
    tag_way    = '0;
    tag_data   = '0;

    if (state_q == REQ) begin
      mem_req  = 1'b1;
      mem_addr = {line_q, {(WO_W+2){1'b0}}};
    end

    if (beat_vld_q) begin
      ram_en     = 1'b1;
      ram_we     = 1'b1;
      ram_index  = fill_index;
      ram_way    = way_q;
      ram_offset = beat_off_q;
      ram_din    = beat_data_q;
    end

    if (state_q == TAG) begin
      tag_we    = 1'b1;
      tag_index = fill_index;
      tag_way   = way_q;
      tag_data  = line_q[LINE_W-1 -: TAG_W];
    end

    if (state_q == DONE) begin
      miss_ack = 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// ---------------------------------------------------------------------------
// tb_icache_line_fill
//   Directed bench for icache_line_fill. A table of miss transactions holds
//   the address, the domain, the grant delay, the inter-beat gaps, and the
//   hand-computed way, index, tag and line address for each transaction. The
//   table is replayed cycle by cycle. Reset at start-up and reset in the
//   middle of a fill are written out by hand.
// ---------------------------------------------------------------------------
module tb_icache_line_fill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_dom = 1'b0;
  logic        miss_ack;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ram_en;
  logic        ram_we;
  logic [4:0]  ram_index;
  logic [1:0]  ram_way;
  logic [1:0]  ram_offset;
  logic [31:0] ram_din;
  logic        tag_we;
  logic [4:0]  tag_index;
  logic [1:0]  tag_way;
  logic [22:0] tag_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]      addr;
    logic             dom;
    int               gntDelay;
    logic [3:0][1:0]  gaps;
    logic [31:0]      dataBase;
    logic [1:0]       expWay;
    logic [4:0]       expIndex;
    logic [22:0]      expTag;
    logic [31:0]      expMemAddr;
  } fillVec_t;

  fillVec_t vecs[6];
  fillVec_t postReset;

  icache_line_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .miss_dom   (miss_dom),
    .miss_ack   (miss_ack),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_index  (ram_index),
    .ram_way    (ram_way),
    .ram_offset (ram_offset),
    .ram_din    (ram_din),
    .tag_we     (tag_we),
    .tag_index  (tag_index),
    .tag_way    (tag_way),
    .tag_data   (tag_data)
  );

  always #5 clk = ~clk;

  // Advance one cycle. Outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one complete miss from request through acknowledge.
  task automatic applyStimulus(input fillVec_t v);
    int writes;
    writes = 0;

    miss_req  = 1'b1;
    miss_addr = v.addr;
    miss_dom  = v.dom;
    tick();
    checkOutput("busy_in_req", busy, 1);

    // Scramble the miss inputs. The captured values must still be used.
    miss_addr = ~v.addr;
    miss_dom  = ~v.dom;

    // Drive junk read beats during REQ. The DUT must ignore them.
    for (int i = 0; i <= v.gntDelay; i++) begin
      checkOutput("mem_req_held", mem_req, 1);
      checkOutput("mem_addr", mem_addr, v.expMemAddr);
      mem_gnt    = (i == v.gntDelay);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_0000 + i;
      tick();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput("mem_req_drop", mem_req, 0);
    checkOutput("no_write_after_gnt", ram_we, 0);

    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(v.gaps[k]); g++) begin
        mem_rvalid = 1'b0;
        tick();
        checkOutput("gap_ram_we", ram_we, 0);
        checkOutput("gap_ram_en", ram_en, 0);
        checkOutput("gap_tag_we", tag_we, 0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.dataBase + k;
      tick();
      if (ram_we === 1'b1) writes++;
      checkOutput("ram_we", ram_we, 1);
      checkOutput("ram_en", ram_en, 1);
      checkOutput("ram_offset", ram_offset, k);
      checkOutput("ram_din", ram_din, v.dataBase + k);
      checkOutput("ram_index", ram_index, v.expIndex);
      checkOutput("ram_way", ram_way, v.expWay);
      checkOutput("tag_we_timing", tag_we, (k == 3));
      checkOutput("ack_early", miss_ack, 0);
    end

    // The cycle above was TAG. Check the tag fields it committed.
    checkOutput("tag_index", tag_index, v.expIndex);
    checkOutput("tag_way", tag_way, v.expWay);
    checkOutput("tag_data", tag_data, v.expTag);

    // A beat beyond the end of the line must not produce a RAM write.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    tick();
    checkOutput("miss_ack", miss_ack, 1);
    checkOutput("extra_beat_ignored", ram_we, 0);
    checkOutput("tag_we_once", tag_we, 0);

    miss_req   = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    checkOutput("ack_pulse", miss_ack, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("write_count", writes, 4);
  endtask

  initial begin
    // addr, dom, gntDelay, gaps{[3],[2],[1],[0]}, data, way, index, tag, memAddr
    vecs[0] = '{32'h0000_1040, 1'b0, 1, 8'h00, 32'h0000_00A0, 2'd0, 5'd4,  23'h8,      32'h0000_1040};
    vecs[1] = '{32'h0000_1040, 1'b1, 0, 8'h00, 32'h0000_00B0, 2'd2, 5'd4,  23'h8,      32'h0000_1040};
    vecs[2] = '{32'h0000_104C, 1'b0, 0, 8'h01, 32'h0000_00C0, 2'd1, 5'd4,  23'h8,      32'h0000_1040};
    vecs[3] = '{32'h0000_1040, 1'b0, 2, 8'h00, 32'h0000_00D0, 2'd0, 5'd4,  23'h8,      32'h0000_1040};
    vecs[4] = '{32'h8000_3FF4, 1'b1, 3, 8'h60, 32'h1234_5670, 2'd2, 5'd31, 23'h40001F, 32'h8000_3FF0};
    vecs[5] = '{32'h0000_1040, 1'b1, 0, 8'h00, 32'h0000_00F0, 2'd3, 5'd4,  23'h8,      32'h0000_1040};
    postReset = '{32'h0000_1040, 1'b0, 0, 8'h00, 32'h0000_00E0, 2'd0, 5'd4, 23'h8, 32'h0000_1040};

    // Assert reset asynchronously before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_tag_we", tag_we, 0);
    checkOutput("rst_miss_ack", miss_ack, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n]);
    end

    // Reset in the middle of a fill, after two beats have been delivered.
    miss_req  = 1'b1;
    miss_addr = 32'h0000_1040;
    miss_dom  = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    tick();
    checkOutput("mid_beat0_we", ram_we, 1);
    mem_rdata = 32'h0000_0056;
    tick();
    checkOutput("mid_beat1_we", ram_we, 1);
    checkOutput("mid_beat1_off", ram_offset, 1);
    mem_rvalid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ram_we", ram_we, 0);
    checkOutput("mid_rst_ram_en", ram_en, 0);
    checkOutput("mid_rst_tag_we", tag_we, 0);
    checkOutput("mid_rst_mem_req", mem_req, 0);
    miss_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("mid_rst_no_tag", tag_we, 0);
      checkOutput("mid_rst_no_ack", miss_ack, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // The low-domain pointer for set 4 was 1 before reset and must now be 0.
    applyStimulus(postReset);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
